// File: rtl/memchr.sv
// Byte-search reader on the memory_controller bus: scans n bytes from m for
// the first byte equal to c[7:0], issuing one read per cycle.
module memchr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] m,
  input  logic [31:0]           c,
  input  logic [31:0]           n,
  output logic                  finish,
  output logic [ADDR_WIDTH-1:0] return_val,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] memory_controller_address,
  output logic                  memory_controller_write_enable,
  output logic [DATA_WIDTH-1:0] memory_controller_in,
  input  logic [DATA_WIDTH-1:0] memory_controller_out,
  output logic [1:0]            state_dbg
);

  // Handshake: start is taken only while idle (m, c, n sampled with it);
  // finish pulses for one cycle, and found/return_val stay valid until the next start.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] m_q;
  logic [7:0]            c_q;
  logic [31:0]           n_q;
  logic [31:0]           issued;
  logic [31:0]           compared;
  logic                  match;
  logic                  last;
  logic                  unused_bits;

  // Read data arriving now belongs to the address currently on the bus.
  assign match = (memory_controller_out[7:0] == c_q);
  assign last  = (compared == n_q - 32'd1);

  assign memory_controller_write_enable = 1'b0;
  assign memory_controller_in           = '0;
  assign state_dbg                      = state;
  assign unused_bits = ^{c[31:8], memory_controller_out[DATA_WIDTH-1:8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = (n == 32'd0) ? S_DONE : S_ISSUE;
      S_ISSUE:  state_next = S_STREAM;
      S_STREAM: if (match || last) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish                    <= 1'b0;
      return_val                <= '0;
      found                     <= 1'b0;
      memory_controller_address <= '0;
      m_q                       <= '0;
      c_q                       <= 8'd0;
      n_q                       <= 32'd0;
      issued                    <= 32'd0;
      compared                  <= 32'd0;
    end else begin
      finish <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            m_q        <= m;
            c_q        <= c[7:0];
            n_q        <= n;
            issued     <= 32'd0;
            compared   <= 32'd0;
            found      <= 1'b0;
            return_val <= '0;
          end
        end
        S_ISSUE: begin
          memory_controller_address <= m_q;
          issued                    <= 32'd1;
        end
        S_STREAM: begin
          compared <= compared + 32'd1;
          // A read issued in the same cycle as a match is simply never compared.
          if (issued < n_q) begin
            memory_controller_address <= memory_controller_address + ADDR_WIDTH'(1);
            issued                    <= issued + 32'd1;
          end
          if (match) begin
            return_val <= memory_controller_address;
            found      <= 1'b1;
          end else if (last) begin
            return_val <= '0;
            found      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memchr.sv
// Randomized and directed checks of memchr against a behavioural search model
// over a 32-byte aliased RAM.
module tb_memchr;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] m;
  logic [31:0] c;
  logic [31:0] n;
  logic        finish;
  logic [31:0] return_val;
  logic        found;
  logic [31:0] mc_address;
  logic        mc_write_enable;
  logic [31:0] mc_in;
  logic [31:0] mc_out;
  logic [1:0]  state_dbg;

  logic [7:0]  ram [32];
  logic [23:0] junk = 24'd0;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Controller decodes addr[4:0]; upper data bits carry noise that must be ignored.
  assign mc_out = {junk, ram[mc_address[4:0]]};
  always @(negedge clk) junk <= 24'($urandom);

  memchr dut (
    .clk                            (clk),
    .reset                          (reset),
    .start                          (start),
    .m                              (m),
    .c                              (c),
    .n                              (n),
    .finish                         (finish),
    .return_val                     (return_val),
    .found                          (found),
    .memory_controller_address      (mc_address),
    .memory_controller_write_enable (mc_write_enable),
    .memory_controller_in           (mc_in),
    .memory_controller_out          (mc_out),
    .state_dbg                      (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First match in the scanned window; latency counted from the start edge.
  task automatic ref_search(input logic [31:0] mm, input logic [7:0] cc, input logic [31:0] nn,
                            output logic fnd, output logic [31:0] ret, output longint lat);
    logic [31:0] a;
    fnd = 1'b0;
    ret = 32'd0;
    lat = (nn == 32'd0) ? 1 : longint'(nn) + 2;
    for (longint i = 0; i < longint'(nn); i++) begin
      a = mm + 32'(i);
      if (ram[a[4:0]] == cc) begin
        fnd = 1'b1;
        ret = a;
        lat = i + 3;
        break;
      end
    end
  endtask

  task automatic do_search(input logic [31:0] mm, input logic [31:0] cc, input logic [31:0] nn);
    logic        e_found;
    logic [31:0] e_ret;
    longint      e_lat;
    longint      n_addr;
    longint      bound;
    int          cyc;
    int          we_bad;
    bit          done;
    logic [31:0] addr_before;

    ref_search(mm, cc[7:0], nn, e_found, e_ret, e_lat);
    n_addr = (e_lat - 2 < longint'(nn)) ? e_lat - 2 : longint'(nn);
    exp_q.delete();
    for (longint j = 0; j < n_addr; j++) exp_q.push_back(mm + 32'(j));
    bound = (e_lat < 200) ? e_lat + 10 : 200;

    addr_before = mc_address;
    @(negedge clk);
    m = mm; c = cc; n = nn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; done = 1'b0; we_bad = 0;
    while (!done && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      if (mc_write_enable !== 1'b0 || mc_in !== 32'd0) we_bad++;
      if (exp_q.size() > 0) check("read_addr", mc_address, exp_q.pop_front());
      if (finish === 1'b1) done = 1'b1;
    end
    if (!done) begin
      check("finish_timeout", 64'(cyc), 64'(e_lat));
    end else begin
      check("latency", 64'(cyc), 64'(e_lat));
      check("found", 64'(found), 64'(e_found));
      check("return_val", 64'(return_val), 64'(e_ret));
    end
    check("write_side_idle", 64'(we_bad), 64'd0);
    if (nn == 32'd0) check("no_read_issued", 64'(mc_address), 64'(addr_before));
    @(posedge clk); #1;
    check("finish_one_cycle", 64'(finish), 64'd0);
    check("found_held", 64'(found), 64'(e_found));
    check("return_held", 64'(return_val), 64'(e_ret));
  endtask

  initial begin
    int fin_seen;
    reset = 1'b0; start = 1'b0; m = 32'd0; c = 32'd0; n = 32'd0;
    for (int i = 0; i < 32; i++) ram[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_return", 64'(return_val), 64'd0);
    check("rst_address", 64'(mc_address), 64'd0);
    check("rst_write_enable", 64'(mc_write_enable), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // "abcdefgh" at 0..7
    for (int i = 0; i < 8; i++) ram[i] = 8'h61 + 8'(i);
    do_search(32'd0, 32'h64, 32'd8);
    do_search(32'd0, 32'hAB00_007A, 32'd8);
    do_search(32'd5, 32'h61, 32'd0);

    for (int i = 0; i < 32; i++) ram[i] = 8'(i);
    ram[5] = 8'h41; ram[9] = 8'h41;
    do_search(32'd2, 32'h41, 32'd10);
    ram[31] = 8'h7E;
    do_search(32'd24, 32'h7E, 32'd8);
    do_search(32'd0, 32'h10, 32'hFFFF_FFFF);
    do_search(32'hFFFF_FFFD, 32'h01, 32'd8);
    do_search(32'd3, 32'h03, 32'd1);
    do_search(32'd3, 32'h04, 32'd1);

    // Asynchronous reset mid-search: outputs clear at once, no finish pulse.
    for (int i = 0; i < 8; i++) ram[i] = 8'h61 + 8'(i);
    @(negedge clk);
    m = 32'd0; c = 32'h7A; n = 32'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_finish", 64'(finish), 64'd0);
    check("abort_found", 64'(found), 64'd0);
    check("abort_return", 64'(return_val), 64'd0);
    check("abort_address", 64'(mc_address), 64'd0);
    fin_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (finish === 1'b1) fin_seen++;
    end
    check("abort_no_finish", 64'(fin_seen), 64'd0);
    do_search(32'd1, 32'h66, 32'd8);

    // Random searches over a small alphabet so both hits and misses occur.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 15));
      do_search($urandom, {24'($urandom), 8'($urandom_range(0, 19))}, 32'($urandom_range(0, 40)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
